// File: rtl/ldm_stm_register_sequencer.sv
// ldm_stm_register_sequencer
// Register-list sequencer for LM/SM instructions. It latches the 8-bit
// register-list field of IR, then emits one register index per cycle with
// the lowest set bit first. Each serviced bit is cleared as the sequence
// advances, and the last transfer is flagged.
//
// Optional feature: define MULTIPLE_PENDING_EN to add the mult_pending
// output. It is 1 while list_q is non-empty, which lets the controller tell
// "last register" apart from "empty list".

module ldm_stm_register_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       selectinput,
  input  logic [7:0] inputfromIR,
  output logic [2:0] pren_out,
`ifdef MULTIPLE_PENDING_EN
  output logic       mult_pending,
`endif
  output logic       flag_multiple
);

  logic [7:0] list_q;
  logic [7:0] list_d;
  logic [7:0] onehot;
  logic [7:0] next_list;
  logic [2:0] pren;

  // List register: written every edge; reset has priority over the mux
  always_ff @(posedge clk) begin
    if (reset) begin
      list_q <= 8'h00;
    end else begin
      list_q <= list_d;
    end
  end

  // Priority encoder: lowest set bit wins; an empty list encodes to 0
  always_comb begin
    pren = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (list_q[i]) begin
        pren = 3'(i);
      end
    end
  end

  // Decode the serviced index and mask it out of the list
  always_comb begin
    onehot    = 8'h01 << pren;
    next_list = list_q & ~onehot;
  end

  // Next-state mux: 0 reloads from IR, 1 advances to the next pending register
  always_comb begin
    if (selectinput) begin
      list_d = next_list;
    end else begin
      list_d = inputfromIR;
    end
  end

  // Outputs depend only on list_q, so they are never X after reset
  always_comb begin
    pren_out      = pren;
    flag_multiple = ~|next_list;
  end

`ifdef MULTIPLE_PENDING_EN
  // Non-empty list means the current pren_out is a real transfer
  always_comb begin
    mult_pending = |list_q;
  end
`endif

endmodule

// File: tb/tb_ldm_stm_register_sequencer.sv
// tb_ldm_stm_register_sequencer
// Scoreboard bench. The stimulus process pushes the hand-computed
// expectation for each edge into a queue, and the monitor pops it and
// compares it on the following falling edge.

module tb_ldm_stm_register_sequencer;

  logic       clk;
  logic       reset;
  logic       selectinput;
  logic [7:0] inputfromIR;
  logic [2:0] pren_out;
  logic       flag_multiple;
`ifdef MULTIPLE_PENDING_EN
  logic       mult_pending;
`endif

  typedef struct {
    string      name;
    logic [7:0] list;
    logic [2:0] pren;
    logic       flag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  ldm_stm_register_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .selectinput   (selectinput),
    .inputfromIR   (inputfromIR),
    .pren_out      (pren_out),
`ifdef MULTIPLE_PENDING_EN
    .mult_pending  (mult_pending),
`endif
    .flag_multiple (flag_multiple)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are stable by the falling edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (pren_out !== e.pren) begin
        bad++;
        $display("FAIL %s pren_out got=%0d want=%0d", e.name, pren_out, e.pren);
      end
      total++;
      if (flag_multiple !== e.flag) begin
        bad++;
        $display("FAIL %s flag_multiple got=%0b want=%0b", e.name, flag_multiple, e.flag);
      end
      total++;
      if (dut.list_q !== e.list) begin
        bad++;
        $display("FAIL %s list_q got=%02h want=%02h", e.name, dut.list_q, e.list);
      end
`ifdef MULTIPLE_PENDING_EN
      total++;
      if (mult_pending !== (e.list != 8'h00)) begin
        bad++;
        $display("FAIL %s mult_pending got=%0b want=%0b", e.name, mult_pending, (e.list != 8'h00));
      end
`endif
    end
  end

  task automatic step(input string name, input logic r, input logic s,
                      input logic [7:0] ir, input logic [7:0] el,
                      input logic [2:0] ep, input logic ef);
    exp_t e;
    reset       = r;
    selectinput = s;
    inputfromIR = ir;
    @(posedge clk);
    e.name = name;
    e.list = el;
    e.pren = ep;
    e.flag = ef;
    sb.push_back(e);
    #1;
  endtask

  initial begin
    logic [7:0] ffl;
    reset       = 1'b1;
    selectinput = 1'b0;
    inputfromIR = 8'h00;
    #2;

    step("reset", 1'b1, 1'b0, 8'h5A, 8'h00, 3'd0, 1'b1);

    step("aa_load",  1'b0, 1'b0, 8'hAA, 8'hAA, 3'd1, 1'b0);
    step("aa_s1",    1'b0, 1'b1, 8'h00, 8'hA8, 3'd3, 1'b0);
    step("aa_s2",    1'b0, 1'b1, 8'h00, 8'hA0, 3'd5, 1'b0);
    step("aa_s3",    1'b0, 1'b1, 8'h00, 8'h80, 3'd7, 1'b1);
    step("aa_s4",    1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b1);
    step("aa_s5",    1'b0, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b1);

    step("ff_load",  1'b0, 1'b0, 8'hFF, 8'hFF, 3'd0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      ffl = 8'hFF << k;
      step($sformatf("ff_s%0d", k), 1'b0, 1'b1, 8'h00, ffl, 3'(k), (k == 7));
    end
    step("ff_s8",    1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b1);

    step("z_load",   1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    step("z_s1",     1'b0, 1'b1, 8'hAA, 8'h00, 3'd0, 1'b1);
    step("z_s2",     1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b1);

    step("r81_load", 1'b0, 1'b0, 8'h81, 8'h81, 3'd0, 1'b0);
    step("r81_s1",   1'b0, 1'b1, 8'h00, 8'h80, 3'd7, 1'b1);
    step("r10_load", 1'b0, 1'b0, 8'h10, 8'h10, 3'd4, 1'b1);

    step("c_load",   1'b0, 1'b0, 8'h0C, 8'h0C, 3'd2, 1'b0);
    step("c_rst",    1'b1, 1'b1, 8'h0C, 8'h00, 3'd0, 1'b1);
    step("c_after",  1'b0, 1'b1, 8'h0C, 8'h00, 3'd0, 1'b1);
    step("c_reload", 1'b0, 1'b0, 8'h0C, 8'h0C, 3'd2, 1'b0);
    step("c_s1",     1'b0, 1'b1, 8'h00, 8'h08, 3'd3, 1'b1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #6;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldm_stm_register_sequencer.md
Name: ldm_stm_register_sequencer

Overview:
- Sequencer for load-multiple / store-multiple (LM/SM) instructions in the multicycle RISC datapath.
- Latches the 8-bit register-list field of the instruction register (IR) and emits one register index per cycle, lowest set bit first.
- Clears each serviced bit and flags the last transfer.
- Built from an 8-bit state register, an 8-bit 2:1 mux, an 8→3 priority encoder, a 3→8 decoder and an 8-bit AND mask stage.

Parameters:
- None. Width is fixed at 8 list bits and a 3-bit index.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-high reset; clears the list register.
- selectinput  input  1  0 = load list from IR; 1 = advance to the next pending register.
- inputfromIR  input  8  register-list field of IR; bit i set = register Ri participates (bit 0 = R0).
- pren_out  output  3  index of the register serviced this cycle.
- flag_multiple  output  1  1 = no registers remain after the current one.

Behaviour:
- State: 8-bit list register `list_q`, written every rising edge (write permanently enabled).
- Reset: at a clk edge with reset=1, `list_q` <= 8'h00. Reset has priority over selectinput. A mid-sequence reset aborts the sequence; the next edge with selectinput=0 reloads.
- Post-reset outputs: pren_out=0, flag_multiple=1.
- pren_out (combinational from `list_q`) = index of the lowest set bit of `list_q`. If `list_q`=0, pren_out=0.
- onehot = 3→8 decode of pren_out, i.e. 1<<pren_out.
- next_list = `list_q` & ~onehot: clears the bit being serviced. If `list_q`=0, next_list=0.
- Next-state mux:
  - selectinput=0: `list_q` <= inputfromIR.
  - selectinput=1: `list_q` <= next_list.
- flag_multiple = ~|next_list, combinational. It is 1 when the current index is the last one, or when the list is empty.
- Latency: pren_out shows the first index one cycle after the load edge. Each following edge with selectinput=1 advances by one index.
- Empty IR list: after the load, pren_out=0 and flag_multiple=1 immediately. The controller must treat an empty list as zero transfers.
- Holding selectinput=1 after the list is exhausted: `list_q` stays 0, pren_out=0, flag_multiple=1. Stable, no wrap-around.
- Loading (selectinput=0) mid-sequence discards the remaining bits and restarts from the new field.
- No X propagation: all outputs are defined from `list_q` alone.

Optional Feature:
- Macro MULTIPLE_PENDING_EN.
- When defined: adds output port `mult_pending` (1 bit) = |`list_q`. It is 1 while the current pren_out is a valid transfer, and 0 after reset and when the list is exhausted. This lets the controller distinguish "last register" from "empty list".
- When undefined: the port does not exist and all other behaviour is identical.

Test Plan:
- Reset: reset=1 for one edge, then reset=0 -> pren_out=0, flag_multiple=1.
- Load 8'b10101010 with selectinput=0, then selectinput=1 for 5 edges -> pren_out sequence 1,3,5,7,0; flag_multiple sequence 0,0,0,1,1; `list_q` sequence A8, A0, 80, 00.
- Load 8'hFF, then step -> indices 0..7 in order; flag_multiple=1 only at index 7; `list_q`=0 after the 8th step.
- Load 8'h00 -> pren_out=0, flag_multiple=1; stepping keeps both unchanged (mult_pending=0 when the macro is enabled).
- Load 8'h81, step once, reload 8'h10 with selectinput=0 -> pren_out 0, then 7, then 4 with flag_multiple=1.
- Load 8'h0C, assert reset together with selectinput=1 -> pren_out=0, flag_multiple=1 next cycle; reset wins over advance.
